// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: two-flop synchroniser, stability-counter
// debounce, registered rise/fall strobes and an auto-repeat press strobe.
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            repeat_en,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] press_pulse
);

  localparam int SW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_WAIT,
    REP_RUN
  } rep_state_e;

  logic [N_CH-1:0] sync0;
  logic [N_CH-1:0] sync1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= btn_raw;
      sync1 <= sync0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          state_q;
    logic          rise_q;
    logic          fall_q;
    logic          press_q;
    logic [SW-1:0] stab_cnt;
    logic          mismatch;
    logic          toggle;
    logic          rise_tog;
    logic          fall_tog;

    rep_state_e    rep_state;
    rep_state_e    rep_state_nx;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_nx;
    logic          rep_strobe;

    // A toggle needs STABLE_CYCLES strictly consecutive disagreeing samples.
    assign mismatch = (sync1[i] != state_q);
    assign toggle   = mismatch && (stab_cnt == STAB_LAST);
    assign rise_tog = toggle && !state_q;
    assign fall_tog = toggle && state_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stab_cnt <= '0;
        state_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        press_q  <= 1'b0;
      end else begin
        if (!mismatch || toggle) begin
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + 1'b1;
        end
        if (toggle) begin
          state_q <= ~state_q;
        end
        rise_q  <= rise_tog;
        fall_q  <= fall_tog;
        press_q <= rise_tog | rep_strobe;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rep_state <= REP_IDLE;
        rep_cnt   <= '0;
      end else begin
        rep_state <= rep_state_nx;
        rep_cnt   <= rep_cnt_nx;
      end
    end

    // Release or losing the enable wins over a strobe due on the same edge.
    always_comb begin
      rep_state_nx = rep_state;
      rep_cnt_nx   = rep_cnt;
      rep_strobe   = 1'b0;
      case (rep_state)
        REP_IDLE: begin
          rep_cnt_nx = '0;
          if (rise_tog && repeat_en) begin
            rep_state_nx = REP_WAIT;
          end
        end
        REP_WAIT: begin
          if (!repeat_en || fall_tog || !state_q) begin
            rep_state_nx = REP_IDLE;
            rep_cnt_nx   = '0;
          end else if (rep_cnt == DELAY_LAST) begin
            rep_strobe   = 1'b1;
            rep_cnt_nx   = '0;
            rep_state_nx = REP_RUN;
          end else begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end
        end
        REP_RUN: begin
          if (!repeat_en || fall_tog || !state_q) begin
            rep_state_nx = REP_IDLE;
            rep_cnt_nx   = '0;
          end else if (rep_cnt == RATE_LAST) begin
            rep_strobe = 1'b1;
            rep_cnt_nx = '0;
          end else begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end
        end
        default: begin
          rep_state_nx = REP_IDLE;
          rep_cnt_nx   = '0;
        end
      endcase
    end

    assign btn_state[i]   = state_q;
    assign rise_pulse[i]  = rise_q;
    assign fall_pulse[i]  = fall_q;
    assign press_pulse[i] = press_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi with small counter constants
// (STABLE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3).
module tb_debounce_multi;

  logic       clk;
  logic       rst;
  logic       repeat_en;
  logic [3:0] btn_raw;
  logic [3:0] btn_state;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] press_pulse;

  int errors = 0;
  int checks = 0;

  debounce_multi #(
    .N_CH(4),
    .STABLE_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_RATE(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .repeat_en(repeat_en),
    .btn_raw(btn_raw),
    .btn_state(btn_state),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .press_pulse(press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] raw, input logic ren);
    btn_raw   = raw;
    repeat_en = ren;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Inputs change before edge 0; the debounced rise must land on edge 5.
  task automatic pressAndWaitRise(input logic [3:0] raw, input logic ren, input string tag);
    applyStimulus(raw, ren);
    for (int k = 0; k < 5; k++) begin
      stepEdge();
      checkOutput({tag, " rise early"}, rise_pulse, 4'b0000);
    end
    stepEdge();
    checkOutput({tag, " rise"}, rise_pulse, raw);
    checkOutput({tag, " press at rise"}, press_pulse, raw);
    checkOutput({tag, " state at rise"}, btn_state, raw);
  endtask

  task automatic releaseAll(input logic ren);
    applyStimulus(4'b0000, ren);
    repeat (10) stepEdge();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    #2;
    checkOutput("reset state", btn_state, 4'b0000);
    checkOutput("reset rise", rise_pulse, 4'b0000);
    checkOutput("reset fall", fall_pulse, 4'b0000);
    checkOutput("reset press", press_pulse, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      stepEdge();
      checkOutput("held in reset", btn_state, 4'b0000);
    end
    applyStimulus(4'b0000, 1'b0);
    rst = 1'b0;
    repeat (3) stepEdge();

    // Clean press and release on channel 0.
    pressAndWaitRise(4'b0001, 1'b0, "t1");
    checkOutput("t1 fall at rise", fall_pulse, 4'b0000);
    stepEdge();
    checkOutput("t1 rise one cycle", rise_pulse, 4'b0000);
    checkOutput("t1 press one cycle", press_pulse, 4'b0000);
    checkOutput("t1 state held", btn_state, 4'b0001);
    applyStimulus(4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      stepEdge();
      checkOutput("t1 release pending", btn_state, 4'b0001);
    end
    stepEdge();
    checkOutput("t1 release state", btn_state, 4'b0000);
    checkOutput("t1 fall", fall_pulse, 4'b0001);
    stepEdge();
    checkOutput("t1 fall one cycle", fall_pulse, 4'b0000);
    releaseAll(1'b0);

    // Bounce on channel 1: 3-cycle runs must never reach the terminal count.
    for (int b = 0; b < 4; b++) begin
      applyStimulus((b % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
      for (int k = 0; k < 3; k++) begin
        stepEdge();
        checkOutput("t2 bounce rise", rise_pulse, 4'b0000);
        checkOutput("t2 bounce state", btn_state, 4'b0000);
      end
    end
    pressAndWaitRise(4'b0010, 1'b0, "t2");
    releaseAll(1'b0);

    // Auto-repeat on channel 2; the strobe due with the fall toggle is dropped.
    pressAndWaitRise(4'b0100, 1'b1, "t3");
    for (int off = 1; off <= 14; off++) begin
      stepEdge();
      checkOutput("t3 repeat", press_pulse,
                  (off == 8 || off == 11 || off == 14) ? 4'b0100 : 4'b0000);
    end
    applyStimulus(4'b0000, 1'b1);
    for (int off = 15; off <= 26; off++) begin
      stepEdge();
      checkOutput("t3 release press", press_pulse, (off == 17) ? 4'b0100 : 4'b0000);
      checkOutput("t3 release fall", fall_pulse, (off == 20) ? 4'b0100 : 4'b0000);
      checkOutput("t3 release state", btn_state, (off < 20) ? 4'b0100 : 4'b0000);
    end

    // repeat_en dropped after the first repeat, then restored while still held.
    pressAndWaitRise(4'b0100, 1'b1, "t4");
    for (int off = 1; off <= 8; off++) begin
      stepEdge();
      checkOutput("t4 first repeat", press_pulse, (off == 8) ? 4'b0100 : 4'b0000);
    end
    applyStimulus(4'b0100, 1'b0);
    for (int off = 9; off <= 20; off++) begin
      stepEdge();
      checkOutput("t4 disabled", press_pulse, 4'b0000);
    end
    applyStimulus(4'b0100, 1'b1);
    for (int off = 21; off <= 35; off++) begin
      stepEdge();
      checkOutput("t4 re-enabled held", press_pulse, 4'b0000);
    end
    releaseAll(1'b1);
    pressAndWaitRise(4'b0100, 1'b1, "t4 re-press");
    for (int off = 1; off <= 8; off++) begin
      stepEdge();
      checkOutput("t4 re-press repeat", press_pulse, (off == 8) ? 4'b0100 : 4'b0000);
    end
    releaseAll(1'b0);

    // Async reset while channel 3 is part-way through a release count.
    pressAndWaitRise(4'b1000, 1'b0, "t5");
    applyStimulus(4'b0000, 1'b0);
    repeat (4) stepEdge();
    checkOutput("t5 mid-count state", btn_state, 4'b1000);
    rst = 1'b1;
    applyStimulus(4'b1000, 1'b0);
    #1;
    checkOutput("t5 async state", btn_state, 4'b0000);
    checkOutput("t5 async rise", rise_pulse, 4'b0000);
    checkOutput("t5 async fall", fall_pulse, 4'b0000);
    checkOutput("t5 async press", press_pulse, 4'b0000);
    stepEdge();
    checkOutput("t5 in reset", btn_state, 4'b0000);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      stepEdge();
      checkOutput("t5 post-reset state", btn_state, 4'b0000);
      checkOutput("t5 post-reset rise", rise_pulse, 4'b0000);
      checkOutput("t5 post-reset fall", fall_pulse, 4'b0000);
    end
    stepEdge();
    checkOutput("t5 new press rise", rise_pulse, 4'b1000);
    checkOutput("t5 new press state", btn_state, 4'b1000);
    releaseAll(1'b0);
    checkOutput("t5 released", btn_state, 4'b0000);

    // Channels 0 and 3 rising on the same edge.
    pressAndWaitRise(4'b1001, 1'b0, "t6");
    stepEdge();
    checkOutput("t6 rise cleared", rise_pulse, 4'b0000);
    checkOutput("t6 state", btn_state, 4'b1001);
    releaseAll(1'b0);
    checkOutput("t6 final state", btn_state, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Synchronises N_CH raw button inputs and filters each with a stability counter, not a plain edge detector.
- Per channel it provides a debounced level, one-cycle rise and fall pulses, and an optional auto-repeat "press" pulse for held buttons.
- Sits between board pushbuttons and the control FSMs, which consume press_pulse as a single-cycle command strobe.

Parameters:
- N_CH, 4: number of independent button channels.
- STABLE_CYCLES, 50000: consecutive synchronised cycles an input must differ from the current debounced state before the state toggles. Must be ≥ 2.
- REPEAT_DELAY, 25000000: cycles from a rise pulse to the first auto-repeat pulse. Must be ≥ 2.
- REPEAT_RATE, 5000000: cycles between consecutive auto-repeat pulses. Must be ≥ 2.
- Counter widths are derived internally with $clog2 of each constant. They are not parameters.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- repeat_en  input  1  global enable for the auto-repeat function.
- btn_raw  input  N_CH  raw, asynchronous button inputs; 1 = pressed.
- btn_state  output  N_CH  debounced level per channel.
- rise_pulse  output  N_CH  one-cycle strobe on each debounced 0->1.
- fall_pulse  output  N_CH  one-cycle strobe on each debounced 1->0.
- press_pulse  output  N_CH  rise_pulse OR auto-repeat strobe.

Behaviour:
- Reset (async, rst=1): all sync flops, counters, btn_state, rise_pulse, fall_pulse and press_pulse clear to 0 immediately and stay 0 while rst=1. No pulse is generated on reset release, even if btn_raw=1; a held button is treated as a new press after STABLE_CYCLES.
- Sync: two-flop synchroniser per channel (sync0 <- btn_raw, sync1 <- sync0). Only sync1 feeds the filter.
- Filter, per channel, with stab_cnt:
  - If sync1 == btn_state: stab_cnt <= 0.
  - Else if stab_cnt == STABLE_CYCLES-1: btn_state <= ~btn_state and stab_cnt <= 0.
  - Else: stab_cnt <= stab_cnt+1.
- Glitch rejection: any return of sync1 to btn_state before the terminal count clears stab_cnt with no output change. Mismatch must be strictly consecutive.
- Latency: if btn_raw changes before edge t and then holds, btn_state changes at edge t+STABLE_CYCLES+1.
- Pulses are registered and asserted in the same edge as the btn_state toggle:
  - rise_pulse=1 for exactly the one cycle after a 0->1 toggle.
  - fall_pulse=1 for exactly the one cycle after a 1->0 toggle.
  - rise_pulse and fall_pulse are never both high on one channel.
- Auto-repeat, per channel, with rep_cnt and state REP_IDLE / REP_WAIT / REP_RUN:
  - REP_IDLE: while btn_state=0 or repeat_en=0, rep_cnt=0.
  - REP_IDLE -> REP_WAIT: on the rise toggle when repeat_en=1; rep_cnt starts at 0.
  - In REP_WAIT: when rep_cnt == REPEAT_DELAY-1, emit a repeat strobe, clear rep_cnt and go to REP_RUN.
  - In REP_RUN: when rep_cnt == REPEAT_RATE-1, emit a strobe and clear rep_cnt.
  - btn_state 1->0 or repeat_en=0, in any state: return to REP_IDLE and clear rep_cnt that same edge. No strobe is emitted on that edge.
  - repeat_en 0->1 while a button is already held does not start repeat; a fresh rise is required.
- press_pulse = registered rise_pulse OR repeat strobe. It is one cycle wide and never wider, even if both coincide.
- Channels are fully independent. Simultaneous events on different channels are each reported in the same cycle.
- No arithmetic overflow is possible: counters clear at their terminal value.

Test Plan:
- Clean press/release (N_CH=4, STABLE_CYCLES=4, repeat_en=0): btn_raw[0] 0->1 before edge 0 and held -> btn_state[0]=1 and rise_pulse[0]=press_pulse[0]=1 after edge 5, for one cycle only. Release -> fall_pulse[0] one cycle after edge +5. Other channels stay 0.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0,1 with each level held 3 cycles, then held 1 -> no rise_pulse during the bounce; btn_state[1] rises exactly 5 edges after the final 0->1.
- Auto-repeat (REPEAT_DELAY=8, REPEAT_RATE=3, repeat_en=1): hold btn_raw[2] -> press_pulse[2] at rise, then at +8, +11, +14 cycles. Release -> no further strobes; fall_pulse[2] is issued.
- repeat_en dropped mid-hold after the first repeat -> no further press_pulse. Re-assert while still held -> still none until release and re-press.
- Async reset mid-count: assert rst for 1 cycle while stab_cnt=2 and btn_state[3]=1 -> all outputs 0 immediately with no clock, and no pulse after release. btn_raw still 1 -> rise after STABLE_CYCLES+1 edges.
- Simultaneous: channels 0 and 3 rise on the same edge -> rise_pulse=4'b1001 in one cycle.
